ibex_lsu_split: RTL

Load/store unit sitting directly upstream of the writeback stage. It accepts one memory request at a time from the execute stage and drives the data-bus request/grant/rvalid protocol. Misaligned accesses are split into two aligned bus transactions. It returns aligned, sign- or zero-extended load data plus a one-cycle response/error pulse, consumed as rf_wdata_lsu_i, rf_we_lsu_i, lsu_resp_valid_i and lsu_resp_err_i by the writeback stage.

---
 rtl/ibex_lsu_split.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ibex_lsu_split.sv
// Load/store unit: one request at a time, misaligned accesses split into two aligned bus beats.
// Optional `IBEX_LSU_REQ_BYPASS_EN drives the first bus request combinationally from lsu_req_i.
module ibex_lsu_split #(
    parameter bit MisalignedEn = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_ready_o,
    output logic        lsu_busy_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i,
    output logic [31:0] rf_wdata_lsu_o,
    output logic        rf_we_lsu_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o
);

    typedef enum logic [2:0] {IDLE, REQ1, RESP1, REQ2, RESP2, ALIGN_ERR} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [1:0]  type_q, type_d;
    logic        sign_ext_q, sign_ext_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata1_q, rdata1_d;

    function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] typ);
        unique case (typ)
            2'b01:   return off == 2'd3;
            2'b10:   return 1'b0;
            default: return off != 2'd0;
        endcase
    endfunction

    logic in_align_err, split_q;
    assign in_align_err = ~MisalignedEn & is_misaligned(lsu_addr_i[1:0], lsu_type_i);
    assign split_q      = MisalignedEn & is_misaligned(addr_q[1:0], type_q);

    // Bus fields come straight from the inputs only while a bypassed request is launched from IDLE.
    logic use_in;
`ifdef IBEX_LSU_REQ_BYPASS_EN
    assign use_in = (state_q == IDLE);
`else
    assign use_in = 1'b0;
`endif

    logic [31:0] cur_addr, cur_wdata;
    logic [1:0]  cur_type;
    logic        cur_we, beat2;
    assign cur_addr  = use_in ? lsu_addr_i  : addr_q;
    assign cur_wdata = use_in ? lsu_wdata_i : wdata_q;
    assign cur_type  = use_in ? lsu_type_i  : type_q;
    assign cur_we    = use_in ? lsu_we_i    : we_q;
    assign beat2     = (state_q == REQ2);

    logic [3:0]  be_base;
    logic [7:0]  be_wide;
    logic [31:0] wdata_rot;
    // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        be_base = 4'b1111;
        unique case (cur_type)
            2'b01:   be_base = 4'b0011;
            2'b10:   be_base = 4'b0001;
            default: be_base = 4'b1111;
        endcase
        wdata_rot = cur_wdata;
        unique case (cur_addr[1:0])
            2'd1:    wdata_rot = {cur_wdata[23:0], cur_wdata[31:24]};
            2'd2:    wdata_rot = {cur_wdata[15:0], cur_wdata[31:16]};
            2'd3:    wdata_rot = {cur_wdata[7:0],  cur_wdata[31:8]};
            default: wdata_rot = cur_wdata;
        endcase
    end
    assign be_wide = {4'b0000, be_base} << cur_addr[1:0];

    always_comb begin
        data_req_o = (state_q == REQ1) || (state_q == REQ2);
`ifdef IBEX_LSU_REQ_BYPASS_EN
        if (state_q == IDLE && lsu_req_i && !in_align_err) data_req_o = 1'b1;
`endif
    end

    assign data_addr_o  = data_req_o ? ({cur_addr[31:2], 2'b00} + (beat2 ? 32'd4 : 32'd0)) : 32'd0;
    assign data_be_o    = data_req_o ? (beat2 ? be_wide[7:4] : be_wide[3:0]) : 4'b0000;
    assign data_we_o    = data_req_o & cur_we;
    assign data_wdata_o = data_req_o ? wdata_rot : 32'd0;
    assign lsu_ready_o  = (state_q == IDLE);
    assign lsu_busy_o   = ~lsu_ready_o;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        type_d     = type_q;
        sign_ext_d = sign_ext_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata1_d   = rdata1_q;
        unique case (state_q)
            IDLE: if (lsu_req_i) begin
                addr_d     = lsu_addr_i;
                we_d       = lsu_we_i;
                type_d     = lsu_type_i;
                sign_ext_d = lsu_sign_ext_i;
                wdata_d    = lsu_wdata_i;
                err_d      = 1'b0;
                if (in_align_err) state_d = ALIGN_ERR;
`ifdef IBEX_LSU_REQ_BYPASS_EN
                else state_d = data_gnt_i ? RESP1 : REQ1;
`else
                else state_d = REQ1;
`endif
            end
            REQ1: if (data_gnt_i) state_d = RESP1;
            RESP1: if (data_rvalid_i) begin
                rdata1_d = data_rdata_i;
                err_d    = err_q | data_err_i;
                state_d  = split_q ? REQ2 : IDLE;
            end
            REQ2:      if (data_gnt_i) state_d = RESP2;
            RESP2:     if (data_rvalid_i) state_d = IDLE;
            ALIGN_ERR: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            type_q     <= 2'b00;
            sign_ext_q <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            type_q     <= type_d;
            sign_ext_q <= sign_ext_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata1_q   <= rdata1_d;
        end
    end

    logic        rvalid_last;
    logic [31:0] beat_lo, ld, ld_ext;
    assign rvalid_last = data_rvalid_i &
                         (((state_q == RESP1) & ~split_q) | (state_q == RESP2));
    assign beat_lo     = (state_q == RESP2) ? rdata1_q : data_rdata_i;

    // Load assembly is {beat2, beat1} shifted right by the byte offset.
    always_comb begin
        ld = beat_lo;
        unique case (addr_q[1:0])
            2'd1:    ld = {data_rdata_i[7:0],  beat_lo[31:8]};
            2'd2:    ld = {data_rdata_i[15:0], beat_lo[31:16]};
            2'd3:    ld = {data_rdata_i[23:0], beat_lo[31:24]};
            default: ld = beat_lo;
        endcase
        ld_ext = ld;
        unique case (type_q)
            2'b01:   ld_ext = {{16{sign_ext_q & ld[15]}}, ld[15:0]};
            2'b10:   ld_ext = {{24{sign_ext_q & ld[7]}}, ld[7:0]};
            default: ld_ext = ld;
        endcase
    end

    assign lsu_resp_valid_o = rvalid_last | (state_q == ALIGN_ERR);
    assign lsu_resp_err_o   = (state_q == ALIGN_ERR) | (rvalid_last & (err_q | data_err_i));
    assign rf_we_lsu_o      = rvalid_last & ~we_q & ~lsu_resp_err_o;
    assign rf_wdata_lsu_o   = rf_we_lsu_o ? ld_ext : 32'd0;

endmodule
